// File: rtl/spi_master_wb.sv
// spi_master_wb: Wishbone-controlled SPI master (mode 0, MSB first).
// A frame is LEAD, a command byte, a data byte, TRAIL, and a one-cycle DONE.
// The slave returns a header during the command byte and data during the data byte.
// Optional header checking is enabled by defining SPI_MASTER_HDRCHK_EN.
module spi_master_wb #(
    parameter int         WIDTH       = 8,
    parameter logic [7:0] HEADER_BYTE = 8'hA7,
    parameter int         CLKDIV      = 4,
    parameter int         DELAY       = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [1:0]       adr_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             ack_o,
    output logic             wat_o,
    output logic             rty_o,
    output logic             err_o,
    output logic             busy_o,
    output logic             hdr_err_o,
    output logic             SCK,
    output logic             SSEL,
    output logic             MOSI,
    input  logic             MISO
);

    // Only the 8-bit configuration is built. DELAY is accepted for compatibility
    // with older benches; this model assigns registers without delay.
    generate
        if (WIDTH != 8 || CLKDIV < 2 || CLKDIV > 255 || DELAY < 0 ||
            $bits(HEADER_BYTE) != WIDTH) begin : g_bad_param
            $error("spi_master_wb: unsupported parameter set");
        end
    endgenerate

    localparam logic [7:0] CNT_MAX = 8'(CLKDIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_CMD, S_DATA, S_TRAIL, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic             sck_q, sck_d;
    logic             ssel_q, ssel_d;
    logic             mosi_q, mosi_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] txd_q, txd_d;
    logic [WIDTH-1:0] cmd_q, cmd_d;
    logic [WIDTH-1:0] rxd_q, rxd_d;
    logic [WIDTH-1:0] dat_q, dat_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_q, ack_d;
    logic             rty_q, rty_d;
    logic             hdr_err_w;
    logic [WIDTH-1:0] status_w;
    logic             req, wr, rd, cmd_wr, half_end;

`ifdef SPI_MASTER_HDRCHK_EN
    logic hdr_err_q, hdr_err_d;
    assign hdr_err_w = hdr_err_q;
`else
    assign hdr_err_w = 1'b0;
`endif

    assign status_w = {5'b0, hdr_err_w, done_q, busy_q};

    // Bus decode, register file updates and the frame sequencer (next-state logic).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sck_d   = sck_q;
        ssel_d  = ssel_q;
        mosi_d  = mosi_q;
        tx_sh_d = tx_sh_q;
        rx_sh_d = rx_sh_q;
        txd_d   = txd_q;
        cmd_d   = cmd_q;
        rxd_d   = rxd_q;
        dat_d   = dat_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef SPI_MASTER_HDRCHK_EN
        hdr_err_d = hdr_err_q;
`endif
        req      = cyc_i & stb_i;
        wr       = req & we_i;
        rd       = req & ~we_i;
        cmd_wr   = wr && (adr_i == 2'd1);
        half_end = (cnt_q == CNT_MAX);

        // A command arriving mid-frame is refused with a retry instead of an ack.
        ack_d = req & ~(cmd_wr & busy_q);
        rty_d = cmd_wr & busy_q;

        if (wr && adr_i == 2'd0) txd_d = dat_i;
        if (rd) begin
            case (adr_i)
                2'd0:    dat_d = rxd_q;
                2'd2:    dat_d = status_w;
                default: dat_d = '0;
            endcase
        end
        if (rd && adr_i == 2'd0) done_d = 1'b0;
`ifdef SPI_MASTER_HDRCHK_EN
        if (rd && adr_i == 2'd2) hdr_err_d = 1'b0;
`endif

        // Sequencer assignments come last so a frame event wins over a bus clear.
        case (state_q)
            S_IDLE: begin
                if (cmd_wr && !busy_q) begin
                    state_d = S_LEAD;
                    cmd_d   = dat_i;
                    ssel_d  = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_LEAD: begin
                cnt_d = cnt_q + 8'd1;
                if (half_end) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_sh_d = cmd_q;
                    mosi_d  = cmd_q[WIDTH-1];
                end
            end
            S_CMD, S_DATA: begin
                cnt_d = cnt_q + 8'd1;
                if (half_end) begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        sck_d   = 1'b1;
                        rx_sh_d = {rx_sh_q[WIDTH-2:0], MISO};
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            bit_d = '0;
                            if (state_q == S_CMD) begin
                                // cmd bit7 set means write: send TXD, else send zeros.
                                state_d = S_DATA;
                                tx_sh_d = cmd_q[WIDTH-1] ? txd_q : '0;
                                mosi_d  = cmd_q[WIDTH-1] & txd_q[WIDTH-1];
`ifdef SPI_MASTER_HDRCHK_EN
                                if (rx_sh_q != HEADER_BYTE) hdr_err_d = 1'b1;
`endif
                            end else begin
                                state_d = S_TRAIL;
                                mosi_d  = 1'b0;
                            end
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
                            mosi_d  = tx_sh_q[WIDTH-2];
                        end
                    end
                end
            end
            S_TRAIL: begin
                cnt_d = cnt_q + 8'd1;
                if (half_end) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ssel_d  = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                rxd_d   = rx_sh_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b0;
            ssel_q  <= 1'b1;
            mosi_q  <= 1'b0;
            tx_sh_q <= '0;
            rx_sh_q <= '0;
            txd_q   <= '0;
            cmd_q   <= '0;
            rxd_q   <= '0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            rty_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sck_q   <= sck_d;
            ssel_q  <= ssel_d;
            mosi_q  <= mosi_d;
            tx_sh_q <= tx_sh_d;
            rx_sh_q <= rx_sh_d;
            txd_q   <= txd_d;
            cmd_q   <= cmd_d;
            rxd_q   <= rxd_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            rty_q   <= rty_d;
        end
    end

`ifdef SPI_MASTER_HDRCHK_EN
    // Sticky header-mismatch flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) hdr_err_q <= 1'b0;
        else       hdr_err_q <= hdr_err_d;
    end
`endif

    assign dat_o     = dat_q;
    assign ack_o     = ack_q;
    assign rty_o     = rty_q;
    assign wat_o     = 1'b0;
    assign err_o     = 1'b0;
    assign busy_o    = busy_q;
    assign hdr_err_o = hdr_err_w;
    assign SCK       = sck_q;
    assign SSEL      = ssel_q;
    assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master_wb.sv
// Directed bench for spi_master_wb with a mode-0 SPI slave model.
`timescale 1ns/1ps
module tb_spi_master_wb;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cyc_i = 1'b0;
    logic       stb_i = 1'b0;
    logic       we_i  = 1'b0;
    logic [1:0] adr_i = 2'd0;
    logic [7:0] dat_i = 8'h00;
    logic [7:0] dat_o;
    logic       ack_o, wat_o, rty_o, err_o, busy_o, hdr_err_o;
    logic       SCK, SSEL, MOSI;
    logic       MISO = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    // Slave model state
    logic [15:0] slv_tx    = 16'h0000;
    logic [15:0] mosi_cap  = 16'h0000;
    int          slv_idx   = 16;
    int          low_cnt   = 0;
    logic        prev_ssel = 1'b1;
    logic        prev_sck  = 1'b0;

    always #5 clk_i = ~clk_i;

    spi_master_wb #(
        .WIDTH(8), .HEADER_BYTE(8'hA7), .CLKDIV(4), .DELAY(3)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .wat_o(wat_o),
        .rty_o(rty_o), .err_o(err_o), .busy_o(busy_o), .hdr_err_o(hdr_err_o),
        .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI), .MISO(MISO)
    );

    // Mode-0 slave: presents data after SSEL falls and after each SCK fall,
    // records MOSI at SCK rises, and counts clk cycles with SSEL low.
    always @(negedge clk_i) begin
        if (SSEL === 1'b0) begin
            if (prev_ssel) begin
                slv_idx  = 0;
                mosi_cap = 16'h0000;
                low_cnt  = 0;
            end
            low_cnt++;
            if (prev_sck && SCK === 1'b0) slv_idx++;
            if (!prev_sck && SCK === 1'b1) mosi_cap = {mosi_cap[14:0], MOSI};
        end
        prev_ssel = (SSEL !== 1'b0);
        prev_sck  = (SCK === 1'b1);
        MISO = (slv_idx < 16) ? slv_tx[15 - slv_idx] : 1'b0;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic we, input logic [1:0] adr, input logic [7:0] wd,
                      output logic [7:0] rdat, output logic ack, output logic rty);
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wd;
        @(negedge clk_i);
        rdat = dat_o; ack = ack_o; rty = rty_o;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        $display("txn we=%0d adr=%0d wdat=%h rdat=%h ack=%0d rty=%0d", we, adr, wd, rdat, ack, rty);
    endtask

    task automatic wr_reg(input string tag, input logic [1:0] adr, input logic [7:0] val);
        logic [7:0] r; logic a, t;
        wb(1'b1, adr, val, r, a, t);
        check({tag, "_ack"}, {15'd0, a}, 16'd1);
    endtask

    task automatic rd_reg(input string tag, input logic [1:0] adr, input logic [7:0] exp);
        logic [7:0] r; logic a, t;
        wb(1'b0, adr, 8'h00, r, a, t);
        check({tag, "_ack"}, {15'd0, a}, 16'd1);
        check(tag, {8'd0, r}, {8'd0, exp});
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_i);
            if (busy_o === 1'b0) break;
        end
        check({tag, "_idle"}, {15'd0, busy_o}, 16'd0);
    endtask

    initial begin
        logic [7:0] r;
        logic a, t;

        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;

        // Reset state
        check("rst_ssel", {15'd0, SSEL}, 16'd1);
        check("rst_sck", {15'd0, SCK}, 16'd0);
        check("rst_mosi", {15'd0, MOSI}, 16'd0);
        check("rst_busy", {15'd0, busy_o}, 16'd0);
        check("rst_ack", {14'd0, ack_o, rty_o}, 16'd0);
        check("rst_hdr", {15'd0, hdr_err_o}, 16'd0);
        rd_reg("rst_status", 2'd2, 8'h00);
        rd_reg("rst_rxd", 2'd0, 8'h00);
        rd_reg("adr3_read", 2'd3, 8'h00);
        check("wat_err", {14'd0, wat_o, err_o}, 16'd0);

        // Write frame
        slv_tx = 16'hA700;
        wr_reg("w_txd", 2'd0, 8'h5C);
        wr_reg("w_cmd", 2'd1, 8'h83);
        check("w_busy", {15'd0, busy_o}, 16'd1);
        wait_idle("w");
        check("w_mosi", mosi_cap, 16'h835C);
        check("w_len", 16'(low_cnt), 16'd137);
        rd_reg("w_status", 2'd2, 8'h02);

        // Read frame
        slv_tx = 16'hA73E;
        wr_reg("r_cmd", 2'd1, 8'h05);
        wait_idle("r");
        check("r_mosi", mosi_cap, 16'h0500);
        rd_reg("r_status_done", 2'd2, 8'h02);
        rd_reg("r_rxd", 2'd0, 8'h3E);
        rd_reg("r_status_clr", 2'd2, 8'h00);

        // Retry: CMD written 10 cycles into the frame
        slv_tx = 16'hA711;
        wr_reg("y_cmd", 2'd1, 8'h83);
        repeat (8) @(negedge clk_i);
        wb(1'b1, 2'd1, 8'h22, r, a, t);
        check("y_rty", {15'd0, t}, 16'd1);
        check("y_ack", {15'd0, a}, 16'd0);
        check("y_busy", {15'd0, busy_o}, 16'd1);
        wait_idle("y");
        check("y_mosi", mosi_cap, 16'h835C);
        rd_reg("y_rxd", 2'd0, 8'h11);

        // Header mismatch
        slv_tx = 16'hFF42;
        wr_reg("h_cmd", 2'd1, 8'h05);
        wait_idle("h");
`ifdef SPI_MASTER_HDRCHK_EN
        check("h_flag", {15'd0, hdr_err_o}, 16'd1);
        rd_reg("h_status", 2'd2, 8'h06);
`else
        check("h_flag", {15'd0, hdr_err_o}, 16'd0);
        rd_reg("h_status", 2'd2, 8'h02);
`endif
        rd_reg("h_status2", 2'd2, 8'h02);
        check("h_flag_clr", {15'd0, hdr_err_o}, 16'd0);
        rd_reg("h_rxd", 2'd0, 8'h42);

        // RXD read coinciding with the DONE cycle
        slv_tx = 16'hA799;
        wr_reg("c_cmd", 2'd1, 8'h05);
        repeat (135) @(negedge clk_i);
        check("c_ssel_136", {15'd0, SSEL}, 16'd0);
        wb(1'b0, 2'd0, 8'h00, r, a, t);
        check("c_ack", {15'd0, a}, 16'd1);
        check("c_old_rxd", {8'd0, r}, 16'h0042);
        check("c_ssel_after", {15'd0, SSEL}, 16'd1);
        rd_reg("c_status", 2'd2, 8'h02);
        rd_reg("c_rxd", 2'd0, 8'h99);

        // Reset during DATA bit 3
        slv_tx = 16'hA755;
        wr_reg("x_cmd", 2'd1, 8'h05);
        repeat (95) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("x_ssel", {15'd0, SSEL}, 16'd1);
        check("x_sck", {15'd0, SCK}, 16'd0);
        check("x_mosi", {15'd0, MOSI}, 16'd0);
        check("x_busy", {15'd0, busy_o}, 16'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check("x_no_resume", {15'd0, SSEL}, 16'd1);
        rd_reg("x_status", 2'd2, 8'h00);
        rd_reg("x_rxd", 2'd0, 8'h00);

        // TXD was cleared by reset: a write frame now sends zeros
        slv_tx = 16'hA700;
        wr_reg("z_cmd", 2'd1, 8'h81);
        wait_idle("z");
        check("z_mosi", mosi_cap, 16'h8100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
